// File: rtl/param_comms_pkg.sv
// Shared types and constants for the parameter RX frame writer.
package param_comms_pkg;

  localparam int PARAM_WORDS = 1024;
  localparam int RAM_ADDR_W  = 11;

  // Status-word field positions
  localparam int STAT_SEQ_LSB   = 16;
  localparam int STAT_COUNT_LSB = 8;
  localparam int STAT_CODE_LSB  = 0;

  // Frame result codes
  localparam logic [1:0] RC_OK      = 2'd0;
  localparam logic [1:0] RC_CHK     = 2'd1;
  localparam logic [1:0] RC_RANGE   = 2'd2;
  localparam logic [1:0] RC_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR_HI = 3'd1,
    ST_ADDR_LO = 3'd2,
    ST_COUNT   = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_CHECK   = 3'd5,
    ST_STATUS  = 3'd6
  } rx_state_e;

  // Pack the commit word that software polls
  function automatic logic [31:0] build_status(input logic [15:0] seq,
                                               input logic [7:0]  count,
                                               input logic [1:0]  code);
    logic [31:0] w;
    w = 32'd0;
    w[STAT_SEQ_LSB   +: 16] = seq;
    w[STAT_COUNT_LSB +: 8]  = count;
    w[STAT_CODE_LSB  +: 2]  = code;
    return w;
  endfunction

endpackage

// File: rtl/param_rx_frame_writer_if.sv
// Byte-stream input and RAM port-2 Avalon write bus of the frame writer.
interface param_rx_frame_writer_if import param_comms_pkg::*; ;
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [RAM_ADDR_W-1:0] ram_address;
  logic [3:0]            ram_byteenable;
  logic                  ram_chipselect;
  logic                  ram_write;
  logic [31:0]           ram_writedata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, ram_address, ram_byteenable, ram_chipselect,
           ram_write, ram_writedata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, ram_address, ram_byteenable, ram_chipselect,
           ram_write, ram_writedata
  );
endinterface

// File: rtl/param_rx_word_assembler.sv
// Collects four bytes (LSB first) into a 32-bit word and flags completion.
module param_rx_word_assembler import param_comms_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word_data,
  output logic        word_done
);

  logic [1:0]  lane_r;
  logic [23:0] shreg_r;

  // The 4th byte completes the word combinationally so the caller can register it
  assign word_data = {byte_data, shreg_r};
  assign word_done = byte_valid & (lane_r == 2'd3);

  // Shift accepted bytes in from the top; clear drops any partial word
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lane_r  <= 2'd0;
      shreg_r <= 24'd0;
    end else if (byte_valid) begin
      lane_r  <= lane_r + 2'd1;
      shreg_r <= {byte_data, shreg_r[23:8]};
    end else begin
      lane_r  <= lane_r;
      shreg_r <= shreg_r;
    end
  end

endmodule

// File: rtl/param_rx_frame_writer.sv
// Frame parser writing parameter words and a per-frame commit word to RAM port 2.
module param_rx_frame_writer import param_comms_pkg::*; #(
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter logic [7:0] SOF_BYTE       = 8'hA5,
  parameter int         STATUS_ADDR    = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  param_rx_frame_writer_if.master  bus,
  output logic                     frame_ok,
  output logic                     frame_err,
  output logic [1:0]               err_code
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  rx_state_e             state_r, state_s;
  logic [TW-1:0]         idle_cnt_r;
  logic [7:0]            chk_sum_r, addr_hi_r, addr_lo_r, count_r, words_left_r;
  logic                  range_err_r;
  logic [RAM_ADDR_W-1:0] word_addr_r;
  logic [15:0]           seq_r, seq_s;
  logic                  rx_ready_r;
  logic                  cs_r, cs_s, ok_r, ok_s, err_r, err_s;
  logic [RAM_ADDR_W-1:0] addr_r, addr_s;
  logic [31:0]           data_r, data_s;
  logic [1:0]            code_r, code_s, result_s;

  logic        accept_s, counting_s, timeout_s, status_fire_s, range_now_s;
  logic        asm_valid_s, word_done_s;
  logic [31:0] word_s;
  logic [16:0] frame_end_s;
  logic [7:0]  sum_final_s;

  assign accept_s    = bus.rx_valid & rx_ready_r;
  assign counting_s  = (state_r != ST_IDLE) && (state_r != ST_STATUS);
  assign timeout_s   = counting_s && !accept_s && (idle_cnt_r == TW'(TIMEOUT_CYCLES - 1));
  assign frame_end_s = {1'b0, addr_hi_r, addr_lo_r} + {9'd0, bus.rx_data};
  assign range_now_s = (bus.rx_data == 8'd0) || (frame_end_s > 17'(PARAM_WORDS));
  assign sum_final_s = chk_sum_r + bus.rx_data;
  assign asm_valid_s = accept_s && (state_r == ST_PAYLOAD);
  assign status_fire_s = timeout_s || ((state_r == ST_CHECK) && accept_s);

  param_rx_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (state_r != ST_PAYLOAD),
    .byte_valid (asm_valid_s),
    .byte_data  (bus.rx_data),
    .word_data  (word_s),
    .word_done  (word_done_s)
  );

  // Next-state decode; a timeout from any in-frame state jumps straight to STATUS
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:    if (accept_s && bus.rx_data == SOF_BYTE) state_s = ST_ADDR_HI;
                  else state_s = ST_IDLE;
      ST_ADDR_HI: if (timeout_s) state_s = ST_STATUS;
                  else if (accept_s) state_s = ST_ADDR_LO;
                  else state_s = ST_ADDR_HI;
      ST_ADDR_LO: if (timeout_s) state_s = ST_STATUS;
                  else if (accept_s) state_s = ST_COUNT;
                  else state_s = ST_ADDR_LO;
      ST_COUNT:   if (timeout_s) state_s = ST_STATUS;
                  else if (accept_s) state_s = (bus.rx_data != 8'd0) ? ST_PAYLOAD : ST_CHECK;
                  else state_s = ST_COUNT;
      ST_PAYLOAD: if (timeout_s) state_s = ST_STATUS;
                  else if (word_done_s && words_left_r == 8'd1) state_s = ST_CHECK;
                  else state_s = ST_PAYLOAD;
      ST_CHECK:   if (timeout_s || accept_s) state_s = ST_STATUS;
                  else state_s = ST_CHECK;
      ST_STATUS:  state_s = ST_IDLE;
      default:    state_s = ST_IDLE;
    endcase
  end

  // Result code of the frame being closed; range beats checksum
  always_comb begin
    result_s = RC_OK;
    if (timeout_s)                result_s = RC_TIMEOUT;
    else if (range_err_r)         result_s = RC_RANGE;
    else if (sum_final_s != 8'd0) result_s = RC_CHK;
    else                          result_s = RC_OK;
  end

  // Next values of the registered outputs: payload write or status commit
  always_comb begin
    cs_s   = 1'b0;
    ok_s   = 1'b0;
    err_s  = 1'b0;
    addr_s = addr_r;
    data_s = data_r;
    code_s = code_r;
    seq_s  = seq_r;
    if (asm_valid_s && word_done_s && !range_err_r) begin
      cs_s   = 1'b1;
      addr_s = word_addr_r;
      data_s = word_s;
    end else if (status_fire_s) begin
      if (result_s == RC_OK) seq_s = seq_r + 16'd1;
      else                   seq_s = seq_r;
      cs_s   = 1'b1;
      addr_s = RAM_ADDR_W'(STATUS_ADDR);
      data_s = build_status(seq_s, count_r, result_s);
      code_s = result_s;
      ok_s   = (result_s == RC_OK);
      err_s  = (result_s != RC_OK);
    end else begin
      cs_s = 1'b0;
    end
  end

  // State register plus frame bookkeeping: checksum, address, word budget, idle timer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      idle_cnt_r   <= '0;
      chk_sum_r    <= 8'd0;
      addr_hi_r    <= 8'd0;
      addr_lo_r    <= 8'd0;
      count_r      <= 8'd0;
      words_left_r <= 8'd0;
      range_err_r  <= 1'b0;
      word_addr_r  <= '0;
    end else begin
      state_r <= state_s;
      if (accept_s)        idle_cnt_r <= '0;
      else if (counting_s) idle_cnt_r <= idle_cnt_r + TW'(1);
      else                 idle_cnt_r <= '0;
      if (accept_s) begin
        case (state_r)
          ST_IDLE: begin
            chk_sum_r   <= 8'd0;
            count_r     <= 8'd0;
            range_err_r <= 1'b0;
          end
          ST_ADDR_HI: begin
            addr_hi_r <= bus.rx_data;
            chk_sum_r <= bus.rx_data;
          end
          ST_ADDR_LO: begin
            addr_lo_r <= bus.rx_data;
            chk_sum_r <= chk_sum_r + bus.rx_data;
          end
          ST_COUNT: begin
            count_r      <= bus.rx_data;
            words_left_r <= bus.rx_data;
            range_err_r  <= range_now_s;
            word_addr_r  <= {addr_hi_r[2:0], addr_lo_r};
            chk_sum_r    <= chk_sum_r + bus.rx_data;
          end
          ST_PAYLOAD: begin
            chk_sum_r <= chk_sum_r + bus.rx_data;
            if (word_done_s) begin
              words_left_r <= words_left_r - 8'd1;
              if (!range_err_r) word_addr_r <= word_addr_r + RAM_ADDR_W'(1);
            end
          end
          default: chk_sum_r <= chk_sum_r;
        endcase
      end
    end
  end

  // Output registers; rx_ready drops only for the STATUS cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_ready_r <= 1'b0;
      cs_r       <= 1'b0;
      ok_r       <= 1'b0;
      err_r      <= 1'b0;
      addr_r     <= '0;
      data_r     <= 32'd0;
      code_r     <= RC_OK;
      seq_r      <= 16'd0;
    end else begin
      rx_ready_r <= (state_s != ST_STATUS);
      cs_r       <= cs_s;
      ok_r       <= ok_s;
      err_r      <= err_s;
      addr_r     <= addr_s;
      data_r     <= data_s;
      code_r     <= code_s;
      seq_r      <= seq_s;
    end
  end

  assign bus.rx_ready       = rx_ready_r;
  assign bus.ram_chipselect = cs_r;
  assign bus.ram_write      = cs_r;
  assign bus.ram_address    = addr_r;
  assign bus.ram_writedata  = data_r;
  assign bus.ram_byteenable = 4'hF;
  assign frame_ok           = ok_r;
  assign frame_err          = err_r;
  assign err_code           = code_r;

endmodule

// File: tb/tb_param_rx_frame_writer.sv
// Scoreboard bench for param_rx_frame_writer: frame-level model feeds an expected-write queue.
module tb_param_rx_frame_writer;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          addr;
    logic [31:0] data;
    bit          is_status;
    int          code;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_ok, frame_err;
  logic [1:0] err_code;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   seq_model = 0;

  always #5 clk = ~clk;

  param_rx_frame_writer_if bus ();

  param_rx_frame_writer dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endfunction

  // Monitor: every RAM write must match the head of the expected queue
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (bus.ram_chipselect === 1'b1) begin
        check("ram_write", {31'd0, bus.ram_write}, 32'd1);
        check("byteenable", {28'd0, bus.ram_byteenable}, 32'hF);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: addr %0d data %h, expected no write",
                   bus.ram_address, bus.ram_writedata);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("addr", {21'd0, bus.ram_address}, e.addr);
          check("data", bus.ram_writedata, e.data);
          if (e.is_status) begin
            check("frame_ok", {31'd0, frame_ok}, (e.code == 0) ? 32'd1 : 32'd0);
            check("frame_err", {31'd0, frame_err}, (e.code != 0) ? 32'd1 : 32'd0);
            check("err_code", {30'd0, err_code}, e.code);
          end else begin
            check("no_pulse_on_payload", {30'd0, frame_ok, frame_err}, 32'd0);
          end
        end
      end else begin
        if (bus.ram_write !== 1'b0 || frame_ok !== 1'b0 || frame_err !== 1'b0) begin
          n_checks++;
          $display("FAIL stray_strobe: write %b ok %b err %b, expected 0 0 0",
                   bus.ram_write, frame_ok, frame_err);
        end
      end
    end
  end

  task automatic idle_cycles(input int n);
    bus.rx_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one byte and hold it until the DUT accepts it
  task automatic send_byte(input logic [7:0] b);
    int tries;
    tries = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    while (bus.rx_ready !== 1'b1 && tries < 8) begin
      tries++;
      @(negedge clk);
    end
    if (bus.rx_ready !== 1'b1) begin
      n_checks++;
      $display("FAIL rx_ready_stuck: got %b, expected 1", bus.rx_ready);
    end
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  function automatic logic [7:0] good_chk(input logic [7:0] ah, input logic [7:0] al,
                                          input logic [7:0] cnt, input bq_t pl);
    int s;
    s = int'(ah) + int'(al) + int'(cnt);
    foreach (pl[i]) s += int'(pl[i]);
    return 8'((256 - (s % 256)) % 256);
  endfunction

  // Frame-level reference: derive writes and commit word from the frame fields
  task automatic model_frame(input logic [7:0] ah, input logic [7:0] al, input logic [7:0] cnt,
                             input bq_t pl, input logic [7:0] chk);
    int   base, s, code;
    bit   rng;
    exp_t e;
    base = int'(ah) * 256 + int'(al);
    rng  = (cnt == 8'd0) || (base + int'(cnt) > 1024);
    s    = int'(ah) + int'(al) + int'(cnt) + int'(chk);
    foreach (pl[i]) s += int'(pl[i]);
    code = rng ? 2 : (((s % 256) != 0) ? 1 : 0);
    if (!rng) begin
      for (int w = 0; w < int'(cnt); w++) begin
        e.addr = base + w;
        e.data = {pl[4*w+3], pl[4*w+2], pl[4*w+1], pl[4*w]};
        e.is_status = 1'b0;
        e.code = 0;
        exp_q.push_back(e);
      end
    end
    if (code == 0) seq_model = (seq_model + 1) % 65536;
    e.addr = 1024;
    e.data = (32'(seq_model) << 16) | (32'(cnt) << 8) | 32'(code);
    e.is_status = 1'b1;
    e.code = code;
    exp_q.push_back(e);
  endtask

  task automatic run_frame(input logic [7:0] ah, input logic [7:0] al, input logic [7:0] cnt,
                           input bq_t pl, input logic [7:0] chk, input bit gaps);
    model_frame(ah, al, cnt, pl, chk);
    send_byte(8'hA5);
    send_byte(ah);
    send_byte(al);
    send_byte(cnt);
    foreach (pl[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
      send_byte(pl[i]);
    end
    send_byte(chk);
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    check("rst_cs", {31'd0, bus.ram_chipselect}, 32'd0);
    check("rst_write", {31'd0, bus.ram_write}, 32'd0);
    check("rst_addr", {21'd0, bus.ram_address}, 32'd0);
    check("rst_data", bus.ram_writedata, 32'd0);
    check("rst_be", {28'd0, bus.ram_byteenable}, 32'hF);
    check("rst_pulses", {30'd0, frame_ok, frame_err}, 32'd0);
    check("rst_err_code", {30'd0, err_code}, 32'd0);
  endtask

  initial begin
    bq_t  p1, pl;
    logic [7:0] ah, al, cnt, chk;
    int   base, kind;
    exp_t e;

    reset = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_cycles(2);
    check("ready_after_reset", {31'd0, bus.rx_ready}, 32'd1);

    // Bad checksum first, then the good version of the same frame
    p1 = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_frame(8'h00, 8'h10, 8'h02, p1, 8'h8B, 1'b0);
    run_frame(8'h00, 8'h10, 8'h02, p1, 8'h8A, 1'b0);
    wait_drain(50);

    // Range errors: end past the top, and an empty frame
    pl = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_frame(8'h03, 8'hFF, 8'h02, pl, good_chk(8'h03, 8'hFF, 8'h02, pl), 1'b0);
    pl = {};
    run_frame(8'h00, 8'h40, 8'h00, pl, good_chk(8'h00, 8'h40, 8'h00, pl), 1'b0);
    wait_drain(50);

    // Stall inside the payload until the idle timer fires
    e.addr = 1024;
    e.data = (32'(seq_model) << 16) | (32'd2 << 8) | 32'd3;
    e.is_status = 1'b1;
    e.code = 3;
    exp_q.push_back(e);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h10);
    send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
    wait_drain(50100);
    foreach (p1[i]) if (i >= 2) send_byte(p1[i]);
    send_byte(8'h8A);
    idle_cycles(5);
    check("dropped_after_timeout", exp_q.size(), 0);

    // Garbage before a frame, then back-to-back good frames
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'hA4);
    run_frame(8'h00, 8'h10, 8'h02, p1, 8'h8A, 1'b0);
    run_frame(8'h00, 8'h10, 8'h02, p1, 8'h8A, 1'b0);
    wait_drain(50);

    // Randomized frames of all kinds, with garbage and gaps
    for (int f = 0; f < 24; f++) begin
      kind = $urandom_range(0, 3);
      cnt  = 8'($urandom_range(1, 6));
      if (kind == 2) base = $urandom_range(1025 - int'(cnt), 1100);
      else           base = $urandom_range(0, 1024 - int'(cnt));
      if (kind == 3) cnt = 8'd0;
      ah = 8'(base >> 8);
      al = 8'(base);
      pl = {};
      for (int i = 0; i < 4 * int'(cnt); i++) pl.push_back(8'($urandom_range(0, 255)));
      chk = good_chk(ah, al, cnt, pl);
      if (kind == 1 || (kind == 2 && $urandom_range(0, 1) == 1))
        chk = chk + 8'($urandom_range(1, 255));
      if ($urandom_range(0, 2) == 0) begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
          logic [7:0] gb;
          gb = 8'($urandom_range(0, 255));
          if (gb == 8'hA5) gb = 8'h00;
          send_byte(gb);
        end
      end
      run_frame(ah, al, cnt, pl, chk, 1'b1);
    end
    wait_drain(100);

    // Reset in the middle of the payload
    pl = {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
    e.addr = 32;
    e.data = 32'hEFBEADDE;
    e.is_status = 1'b0;
    e.code = 0;
    exp_q.push_back(e);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h20); send_byte(8'h02);
    for (int i = 0; i < 6; i++) send_byte(pl[i]);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
    seq_model = 0;
    idle_cycles(3);
    check("ready_after_mid_reset", {31'd0, bus.rx_ready}, 32'd1);
    check("no_write_after_reset", exp_q.size(), 0);
    run_frame(8'h00, 8'h10, 8'h02, p1, 8'h8A, 1'b0);
    wait_drain(50);

    idle_cycles(5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/param_rx_frame_writer.md
# param_rx_frame_writer

Byte-stream frame parser that sits directly upstream of the parameter RX dual-port RAM and drives its second (port-2) Avalon write interface. It accepts framed parameter bursts from the serial comms receiver, assembles little-endian 32-bit words, and writes them into RAM words 0..1023. At the end of every frame it writes a status/commit word to RAM word 1024, which the software side polls.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 50000: inter-byte idle limit while inside a frame.
- `SOF_BYTE`, default 8'hA5: start-of-frame marker.
- `STATUS_ADDR`, default 1024: RAM word that receives the status word.

Ports:
- `clk`, in, 1: single clock. The RAM port-2 clock is driven from this same clock.
- `reset`, in, 1: synchronous, active-high.
- `rx_data`, in, 8: received byte.
- `rx_valid`, in, 1: `rx_data` is valid.
- `rx_ready`, out, 1: block accepts a byte. A byte transfers when `rx_valid` and `rx_ready` are both high.
- `ram_address`, out, 11: word address to RAM port 2.
- `ram_byteenable`, out, 4: always 4'hF when writing.
- `ram_chipselect`, out, 1: port-2 chipselect.
- `ram_write`, out, 1: port-2 write. Always equal to `ram_chipselect`.
- `ram_writedata`, out, 32: write data.
- `frame_ok`, out, 1: one-cycle pulse when a good frame's status word is written.
- `frame_err`, out, 1: one-cycle pulse when a failed frame's status word is written.
- `err_code`, out, 2: result code of the last frame. Held until the next frame ends.

## Operation

- Frame format: SOF, ADDR_HI, ADDR_LO, COUNT, then 4×COUNT payload bytes (LSB first per word), then CHK.
- Checksum rule: the 8-bit sum of ADDR_HI through CHK, modulo 256, must equal 0.
- FSM states: IDLE, ADDR_HI, ADDR_LO, COUNT, PAYLOAD, CHECK, STATUS.
- IDLE: bytes other than SOF_BYTE are discarded. SOF_BYTE moves to ADDR_HI.
- ADDR_HI → ADDR_LO → COUNT: one accepted byte each.
- COUNT: the range check is computed in 17-bit arithmetic.
  - range_err = (COUNT==0) or ({ADDR_HI,ADDR_LO} + COUNT > 1024).
  - Next state: PAYLOAD if COUNT≠0, otherwise CHECK.
- PAYLOAD: bytes are shifted into a 32-bit assembler.
  - On every 4th byte, if not range_err: issue one RAM write at the current word address, then increment the word address.
  - If range_err, bytes are consumed with no writes.
  - After the last payload byte, go to CHECK.
- CHECK: the CHK byte is accepted and the result code is computed. Go to STATUS.
  - 0 = ok, 1 = checksum error, 2 = range error, 3 = timeout.
  - Range error takes precedence over checksum error.
- STATUS: writes the status word to STATUS_ADDR, pulses `frame_ok` (code 0) or `frame_err` (otherwise), updates `err_code`, then returns to IDLE.
  - Status word layout: [31:16] good-frame sequence count (incremented only on code 0, wraps 16'hFFFF→0); [15:8] COUNT; [7:2] zero; [1:0] code.
- Payload writes are not rolled back on checksum failure. The status word is the commit indicator for software.
- Timeout: an idle counter clears on every accepted byte and counts in every state except IDLE and STATUS.
  - On reaching TIMEOUT_CYCLES−1 the FSM goes to STATUS with code 3.
  - A partially assembled word is discarded.
- Reset mid-frame: return to IDLE with no status write; the sequence count clears.

## Timing

- Reset values: `rx_ready`=0 during reset and 1 from the first cycle after; `ram_chipselect`=`ram_write`=0; `ram_address`=0; `ram_writedata`=0; `ram_byteenable`=4'hF; `frame_ok`=`frame_err`=0; `err_code`=0.
- All outputs are registered.
- Payload write: the strobe is high for exactly one cycle, the cycle after the 4th byte of a word is accepted. Address and data are valid in that same cycle.
- Status write: one cycle after the CHK byte is accepted (or after the timeout fires). `frame_ok`/`frame_err` are asserted in that same cycle.
- `rx_ready` is low only in the STATUS cycle. Sustained throughput is one byte per cycle.
- Ports 1 and 2 may collide on the same address. The RAM's mixed-port behaviour is don't-care, so software must read only after the status word changes.

## Structure

- Shared package `param_comms_pkg` holds:
  - the FSM state enum;
  - the result-code constants (OK/CHK/RANGE/TIMEOUT);
  - the status-word field positions;
  - `PARAM_WORDS`=1024.
- Sub-module `param_rx_word_assembler`: byte shifter, byte-lane counter, and word-complete strobe.
- The FSM, checksum accumulator and timeout counter live in the top.

## Test plan

- Good frame: A5 00 10 02 | 11 22 33 44 | 55 66 77 88 | CHK=0x8A → writes 0x44332211 @16 and 0x88776655 @17, then status 0x0001_0200 @1024, `frame_ok` pulse.
- Same frame with CHK=0x8B → both payload writes occur, status 0x0000_0201, `frame_err`=1, `err_code`=1.
- A5 03 FF 02 plus 8 bytes plus valid CHK (range 1023+2>1024) → no payload writes, status code 2. The same range check applies for COUNT=0.
- Stall 50000 cycles after the 6th byte of the good frame → status code 3 at timeout. Following bytes are dropped until the next 0xA5.
- Garbage 00 FF A4 before a good frame → ignored; the frame completes normally. Back-to-back good frames give sequence counts 1 then 2.
- Assert `reset` mid-payload → no further writes, no status write, all outputs at reset values. A good frame afterwards yields sequence count 1.
